// File: rtl/vmx_pkg.sv
// Shared definitions for the vector-MAC chain: feeder FSM states and PE tag layout.
// The PEs (vmx_pe_16_8) decode the same tag constants.
package vmx_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned TAG_LOAD_BIT = 7;
    localparam int unsigned TAG_IDX_W    = 7;
    localparam int unsigned TAG_W        = TAG_IDX_W + 1;
    localparam int unsigned MAX_PE       = 127;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain
    } feeder_state_e;

endpackage

// File: rtl/vmx_chain_feeder.sv
// Head-of-chain sequencer for the systolic vector-MAC PEs: loads per-PE weights, streams data,
// then flushes the chain with bubbles. Define VMX_FEEDER_PERF_EN to add the stall_cnt output.
module vmx_chain_feeder
    import vmx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SUM_W  = 2 * DATA_W,
    parameter int unsigned NUM_PE = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [TAG_IDX_W-1:0] cfg_num_w,
    input  logic [CNT_W-1:0]     cfg_num_vec,
    input  logic                 cfg_simd,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic [DATA_W-1:0]    pe_data,
    output logic [TAG_W-1:0]     pe_is_weight,
    output logic                 pe_simd_mode,
    output logic [SUM_W-1:0]     pe_sum_in,
    output logic                 busy,
`ifdef VMX_FEEDER_PERF_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic                 job_done
);

    localparam logic [TAG_IDX_W-1:0] NUM_PE_L   = TAG_IDX_W'(NUM_PE);
    localparam logic [TAG_IDX_W-1:0] DRAIN_LAST = TAG_IDX_W'(NUM_PE - 1);
    localparam logic [TAG_IDX_W:0]   WIDX_ONE   = (TAG_IDX_W + 1)'(1);
    localparam logic [CNT_W:0]       VCNT_ONE   = (CNT_W + 1)'(1);

    feeder_state_e        state_q, state_d;
    logic [TAG_IDX_W-1:0] nw_q, nw_d, nw_clamp;
    logic [CNT_W-1:0]     nv_q, nv_d;
    logic                 simd_q, simd_d;
    logic [TAG_IDX_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0]     vcnt_q, vcnt_d;
    logic [TAG_IDX_W-1:0] dcnt_q, dcnt_d;
    logic [DATA_W-1:0]    pe_data_q, pe_data_d;
    logic [TAG_W-1:0]     pe_tag_q, pe_tag_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hs, start_ok;
    logic [TAG_IDX_W:0]   widx_inc;
    logic [CNT_W:0]       vcnt_inc;

    assign in_ready = (state_q == StLoadW) || (state_q == StStream);
    assign hs       = in_valid && in_ready;
    // Starts landing on the job_done cycle see busy still high and are dropped.
    assign start_ok = cfg_start && (state_q == StIdle) && !busy_q;
    assign nw_clamp = (cfg_num_w > NUM_PE_L) ? NUM_PE_L : cfg_num_w;
    assign widx_inc = {1'b0, widx_q} + WIDX_ONE;
    assign vcnt_inc = {1'b0, vcnt_q} + VCNT_ONE;

    always_comb begin
        state_d   = state_q;
        nw_d      = nw_q;
        nv_d      = nv_q;
        simd_d    = simd_q;
        widx_d    = widx_q;
        vcnt_d    = vcnt_q;
        dcnt_d    = dcnt_q;
        busy_d    = done_q ? 1'b0 : busy_q;
        done_d    = 1'b0;
        pe_data_d = hs ? in_data : '0;
        pe_tag_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    nw_d   = nw_clamp;
                    nv_d   = cfg_num_vec;
                    simd_d = cfg_simd;
                    widx_d = '0;
                    vcnt_d = '0;
                    dcnt_d = '0;
                    busy_d = 1'b1;
                    if (nw_clamp != '0) begin
                        state_d = StLoadW;
                    end else if (cfg_num_vec != '0) begin
                        state_d = StStream;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StLoadW: begin
                if (hs) begin
                    pe_tag_d[TAG_LOAD_BIT]    = 1'b1;
                    pe_tag_d[TAG_IDX_W-1:0]   = widx_q;
                    widx_d                    = widx_inc[TAG_IDX_W-1:0];
                    if (widx_inc == {1'b0, nw_q}) begin
                        state_d = (nv_q != '0) ? StStream : StDrain;
                    end
                end
            end
            StStream: begin
                if (hs) begin
                    vcnt_d = vcnt_inc[CNT_W-1:0];
                    if (vcnt_inc == {1'b0, nv_q}) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                dcnt_d = dcnt_q + TAG_IDX_W'(1);
                if (dcnt_q == DRAIN_LAST) begin
                    dcnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            nw_q      <= '0;
            nv_q      <= '0;
            simd_q    <= 1'b0;
            widx_q    <= '0;
            vcnt_q    <= '0;
            dcnt_q    <= '0;
            pe_data_q <= '0;
            pe_tag_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nw_q      <= nw_d;
            nv_q      <= nv_d;
            simd_q    <= simd_d;
            widx_q    <= widx_d;
            vcnt_q    <= vcnt_d;
            dcnt_q    <= dcnt_d;
            pe_data_q <= pe_data_d;
            pe_tag_q  <= pe_tag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pe_data      = pe_data_q;
    assign pe_is_weight = pe_tag_q;
    assign pe_simd_mode = simd_q;
    assign pe_sum_in    = '0;
    assign busy         = busy_q;
    assign job_done     = done_q;

`ifdef VMX_FEEDER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (in_ready && !in_valid && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vmx_chain_feeder.sv
// Directed bench for vmx_chain_feeder: a NUM_PE=4 instance for most jobs and a NUM_PE=8
// instance for weight-count clamping.
module tb_vmx_chain_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0;
    logic        start8 = 1'b0;
    logic [6:0]  num_w = '0;
    logic [15:0] num_vec = '0;
    logic        simd = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;

    logic        rdy4, simd4, busy4, done4;
    logic [15:0] data4;
    logic [7:0]  tag4;
    logic [31:0] sum4;
    logic        rdy8, simd8, busy8, done8;
    logic [15:0] data8;
    logic [7:0]  tag8;
    logic [31:0] sum8;
`ifdef VMX_FEEDER_PERF_EN
    logic [31:0] stall4, stall8;
`endif

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    vmx_chain_feeder #(.DATA_W(16), .SUM_W(32), .NUM_PE(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_start(start4), .cfg_num_w(num_w),
        .cfg_num_vec(num_vec), .cfg_simd(simd), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .pe_data(data4), .pe_is_weight(tag4), .pe_simd_mode(simd4),
        .pe_sum_in(sum4), .busy(busy4),
`ifdef VMX_FEEDER_PERF_EN
        .stall_cnt(stall4),
`endif
        .job_done(done4)
    );

    vmx_chain_feeder #(.DATA_W(16), .SUM_W(32), .NUM_PE(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_start(start8), .cfg_num_w(num_w),
        .cfg_num_vec(num_vec), .cfg_simd(simd), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .pe_data(data8), .pe_is_weight(tag8), .pe_simd_mode(simd8),
        .pe_sum_in(sum8), .busy(busy8),
`ifdef VMX_FEEDER_PERF_EN
        .stall_cnt(stall8),
`endif
        .job_done(done8)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        nvec++;
        if ({rdy4, data4, tag4, simd4, busy4, done4} !== '0) begin
            nfail++;
            $display("FAIL reset_outs: got rdy=%b data=%h tag=%h simd=%b busy=%b done=%b, want all 0",
                     rdy4, data4, tag4, simd4, busy4, done4);
        end
        nvec++;
        if (sum4 !== 32'h0 || sum8 !== 32'h0) begin
            nfail++;
            $display("FAIL reset_sum: got %h/%h, want 0", sum4, sum8);
        end
        step;
        rst_n = 1'b1;
        step;
        nvec++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0 || tag4 !== 8'h00) begin
            nfail++;
            $display("FAIL idle_after_reset: got busy=%b rdy=%b tag=%h, want 0 0 00",
                     busy4, rdy4, tag4);
        end
    endtask

    // Shared by the no-stall and alternating-stall jobs: 4 weights, 3 data words.
    task automatic run_job_4w3v(input logic [9:0] vpat, input int ncyc, input string nm);
        int k;
        logic [15:0] exp_d;
        logic [7:0]  exp_t;
        num_w = 7'd4; num_vec = 16'd3; simd = 1'b0; start4 = 1'b1; in_valid = 1'b0;
        step;
        start4 = 1'b0;
        nvec++;
        if (busy4 !== 1'b1 || rdy4 !== 1'b1 || simd4 !== 1'b0) begin
            nfail++;
            $display("FAIL %s_start: got busy=%b rdy=%b simd=%b, want 1 1 0", nm, busy4, rdy4, simd4);
        end
        k = 0;
        for (int i = 0; i < ncyc; i++) begin
            in_valid = vpat[i];
            in_data  = vpat[i] ? 16'(k + 1) : 16'hbeef;
            step;
            if (vpat[i]) begin
                exp_d = 16'(k + 1);
                exp_t = (k < 4) ? 8'(8'h80 + k) : 8'h00;
                k++;
            end else begin
                exp_d = 16'h0;
                exp_t = 8'h00;
            end
            nvec++;
            if (data4 !== exp_d || tag4 !== exp_t) begin
                nfail++;
                $display("FAIL %s_cyc%0d: got data=%h tag=%h, want data=%h tag=%h",
                         nm, i, data4, tag4, exp_d, exp_t);
            end
        end
        in_valid = 1'b1;
        in_data  = 16'hdead;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rdy4 !== 1'b0) begin
                nfail++;
                $display("FAIL %s_drain_rdy%0d: got %b, want 0", nm, i, rdy4);
            end
            step;
            nvec++;
            if (data4 !== 16'h0 || tag4 !== 8'h00 || done4 !== (i == 3) || busy4 !== 1'b1) begin
                nfail++;
                $display("FAIL %s_drain%0d: got data=%h tag=%h done=%b busy=%b, want 0 00 %b 1",
                         nm, i, data4, tag4, done4, busy4, (i == 3));
            end
        end
        in_valid = 1'b0;
        step;
        nvec++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            nfail++;
            $display("FAIL %s_end: got done=%b busy=%b, want 0 0", nm, done4, busy4);
        end
    endtask

    task automatic test_basic;
        run_job_4w3v(10'b00_0111_1111, 7, "basic");
    endtask

    task automatic test_stall;
        // Valid on cycles 0,2,4,6 in LOAD_W, then continuous data.
        run_job_4w3v(10'b11_1101_0101, 10, "stall");
`ifdef VMX_FEEDER_PERF_EN
        nvec++;
        if (stall4 !== 32'd3) begin
            nfail++;
            $display("FAIL stall_cnt: got %0d, want 3", stall4);
        end
`endif
    endtask

    task automatic test_empty;
        num_w = 7'd0; num_vec = 16'd0; simd = 1'b0; start4 = 1'b1; in_valid = 1'b1;
        in_data = 16'h1234;
        step;
        start4 = 1'b0;
        nvec++;
        if (busy4 !== 1'b1) begin
            nfail++;
            $display("FAIL empty_busy: got %b, want 1", busy4);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rdy4 !== 1'b0) begin
                nfail++;
                $display("FAIL empty_rdy%0d: got %b, want 0", i, rdy4);
            end
            step;
            nvec++;
            if (data4 !== 16'h0 || tag4 !== 8'h00 || done4 !== (i == 3)) begin
                nfail++;
                $display("FAIL empty_drain%0d: got data=%h tag=%h done=%b, want 0 00 %b",
                         i, data4, tag4, done4, (i == 3));
            end
        end
        in_valid = 1'b0;
        step;
        nvec++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin
            nfail++;
            $display("FAIL empty_end: got busy=%b rdy=%b, want 0 0", busy4, rdy4);
        end
    endtask

    task automatic test_clamp;
        logic [7:0] exp_t;
        num_w = 7'd100; num_vec = 16'd2; simd = 1'b1; start8 = 1'b1; in_valid = 1'b0;
        step;
        start8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (rdy8 !== 1'b1) begin
                nfail++;
                $display("FAIL clamp_rdy%0d: got %b, want 1", i, rdy8);
            end
            in_valid = 1'b1;
            in_data  = 16'(16'h0100 + i);
            step;
            exp_t = (i < 8) ? 8'(8'h80 + i) : 8'h00;
            nvec++;
            if (data8 !== 16'(16'h0100 + i) || tag8 !== exp_t || simd8 !== 1'b1) begin
                nfail++;
                $display("FAIL clamp_word%0d: got data=%h tag=%h simd=%b, want %h %h 1",
                         i, data8, tag8, simd8, 16'(16'h0100 + i), exp_t);
            end
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (rdy8 !== 1'b0) begin
                nfail++;
                $display("FAIL clamp_drain_rdy%0d: got %b, want 0", i, rdy8);
            end
            step;
            nvec++;
            if (tag8 !== 8'h00 || data8 !== 16'h0 || done8 !== (i == 7)) begin
                nfail++;
                $display("FAIL clamp_drain%0d: got data=%h tag=%h done=%b, want 0 00 %b",
                         i, data8, tag8, done8, (i == 7));
            end
        end
        in_valid = 1'b0;
        step;
        nvec++;
        if (busy8 !== 1'b0) begin
            nfail++;
            $display("FAIL clamp_end: got busy=%b, want 0", busy8);
        end
    endtask

    task automatic test_restart_ignored;
        num_w = 7'd0; num_vec = 16'd4; simd = 1'b1; start4 = 1'b1; in_valid = 1'b0;
        step;
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                start4 = 1'b1; simd = 1'b0; num_w = 7'd4; num_vec = 16'd1;
            end else begin
                start4 = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = 16'(16'h0040 + i);
            step;
            nvec++;
            if (tag4 !== 8'h00 || data4 !== 16'(16'h0040 + i) || simd4 !== 1'b1) begin
                nfail++;
                $display("FAIL restart_word%0d: got data=%h tag=%h simd=%b, want %h 00 1",
                         i, data4, tag4, simd4, 16'(16'h0040 + i));
            end
        end
        start4 = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            nvec++;
            if (simd4 !== 1'b1 || done4 !== (i == 3)) begin
                nfail++;
                $display("FAIL restart_drain%0d: got simd=%b done=%b, want 1 %b",
                         i, simd4, done4, (i == 3));
            end
        end
        // job_done is high now; a start in this cycle must be dropped.
        start4 = 1'b1; num_w = 7'd0; num_vec = 16'd0; simd = 1'b0;
        step;
        start4 = 1'b0;
        nvec++;
        if (busy4 !== 1'b0 || simd4 !== 1'b1) begin
            nfail++;
            $display("FAIL start_on_done: got busy=%b simd=%b, want 0 1", busy4, simd4);
        end
    endtask

    task automatic test_reset_mid;
        num_w = 7'd2; num_vec = 16'd5; simd = 1'b1; start4 = 1'b1; in_valid = 1'b0;
        step;
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0a00 + i);
            step;
        end
        nvec++;
        if (data4 !== 16'h0a03 || tag4 !== 8'h00 || busy4 !== 1'b1) begin
            nfail++;
            $display("FAIL pre_reset: got data=%h tag=%h busy=%b, want 0a03 00 1",
                     data4, tag4, busy4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({rdy4, data4, tag4, simd4, busy4, done4} !== '0) begin
            nfail++;
            $display("FAIL async_reset: got rdy=%b data=%h tag=%h simd=%b busy=%b done=%b, want 0",
                     rdy4, data4, tag4, simd4, busy4, done4);
        end
        in_valid = 1'b0;
        step;
        rst_n = 1'b1;
        num_w = 7'd1; num_vec = 16'd1; simd = 1'b0; start4 = 1'b1;
        step;
        start4 = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0077;
        step;
        nvec++;
        if (data4 !== 16'h0077 || tag4 !== 8'h80) begin
            nfail++;
            $display("FAIL rerun_w: got data=%h tag=%h, want 0077 80", data4, tag4);
        end
        in_data = 16'h0078;
        step;
        nvec++;
        if (data4 !== 16'h0078 || tag4 !== 8'h00 || simd4 !== 1'b0) begin
            nfail++;
            $display("FAIL rerun_v: got data=%h tag=%h simd=%b, want 0078 00 0",
                     data4, tag4, simd4);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            nvec++;
            if (done4 !== (i == 3) || tag4 !== 8'h00) begin
                nfail++;
                $display("FAIL rerun_drain%0d: got done=%b tag=%h, want %b 00",
                         i, done4, tag4, (i == 3));
            end
        end
        step;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_empty;
        test_clamp;
        test_restart_ignored;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/vmx_chain_feeder.md
Name: vmx_chain_feeder

Overview:
- Upstream sequencer that drives the head of a linear chain of 16-bit systolic vector-MAC PEs.
- Accepts a valid/ready word stream and a job descriptor. Emits per-cycle data, weight-load tags and SIMD mode into PE0, and drives the chain's sum input to zero.
- Tags weight words so that each PE latches its own weight as the word ripples down the chain. The weight tag is decremented once per PE hop.

Parameters:
- DATA_W, 16, data word width; must match PE vector width.
- SUM_W, 2*DATA_W, width of the chain head sum output.
- NUM_PE, 8, physical PE count in the chain; legal range 1..127.
- CNT_W, 16, width of the vector counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle job start pulse
- cfg_num_w  in  7  number of weights to load (0..127)
- cfg_num_vec  in  CNT_W  number of data words to stream
- cfg_simd  in  1  1 = dual 8-bit lanes, 0 = 16-bit
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  DATA_W  weight or data word
- pe_data  out  DATA_W  to PE0 data
- pe_is_weight  out  8  to PE0 tag: bit7 = load, [6:0] = target PE index
- pe_simd_mode  out  1  to PE0 mode
- pe_sum_in  out  SUM_W  to PE0 sum input, constant 0
- busy  out  1  high from accepted cfg_start until done
- job_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched config 0.
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE:
  - in_ready=0; busy=0.
  - On cfg_start, latch the job:
    - nw = min(cfg_num_w, NUM_PE); a value above NUM_PE is clamped to NUM_PE.
    - nv = cfg_num_vec.
    - simd = cfg_simd.
  - Next state: LOAD_W if nw>0; else STREAM if nv>0; else DRAIN.
- LOAD_W:
  - in_ready=1.
  - Accepted word i (0-based) is emitted with pe_is_weight={1'b1, i[6:0]}.
  - After the nw-th accept: go to STREAM if nv>0, else DRAIN.
- STREAM:
  - in_ready=1.
  - Each accepted word is emitted with pe_is_weight=8'h00.
  - After the nv-th accept: go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Emits exactly NUM_PE bubble cycles to flush the chain.
  - On the last bubble cycle, raise job_done for 1 cycle.
  - Next cycle: IDLE, busy=0.
- Bubbles: in any non-IDLE cycle without a handshake, emit pe_data=0 and pe_is_weight=8'h00. A bubble never sets bit7, so no spurious weight load occurs.
- Latency: all pe_* outputs are registered, so 1 cycle from handshake to PE0 input.
- pe_simd_mode:
  - Equals the latched simd from the cycle after cfg_start until the end of DRAIN.
  - Held in IDLE.
  - Never changes mid-job.
- pe_sum_in is tied to 0 and is not registered state.
- cfg_start while busy=1 is ignored; the latched config is unchanged.
- job_done and cfg_start in the same cycle: the start is ignored. The new job is accepted from the cycle after busy falls.
- Vector counter: compares against nv with no wrap; nv up to 2^CNT_W-1 is legal.
- Asynchronous reset mid-job: immediate return to IDLE with outputs cleared. Any partially loaded PE weights are left as-is; software restarts the job.

Optional Feature:
- Macro VMX_FEEDER_PERF_EN.
- Defined:
  - Adds output stall_cnt[31:0], which counts bubble cycles in LOAD_W and STREAM.
  - The counter clears on accepted cfg_start, saturates at 2^32-1, and holds after job_done.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package vmx_pkg holds:
  - state enum (IDLE/LOAD_W/STREAM/DRAIN);
  - TAG_LOAD_BIT=7 and TAG_IDX_W=7;
  - MAX_PE=127;
  - the DATA_W default.
- vmx_pe_16_8 uses the same tag constants.
- No sub-module; the FSM and counters stay in one module.

Test Plan:
- NUM_PE=4; cfg_num_w=4, cfg_num_vec=3, simd=0; weights 1,2,3,4, then data 5,6,7, no stalls. Expect:
  - pe_is_weight 0x80,0x81,0x82,0x83,0x00,0x00,0x00;
  - 4 DRAIN bubbles;
  - job_done 11 cycles after the first accept.
  - With PEs attached, PE k holds weight k+1.
- Same job with in_valid low on alternate cycles in LOAD_W. Expect bubble tags 0x00 between weights, and the tag index still increments only on handshakes (0x80,0x00,0x81,...).
- cfg_num_w=0, cfg_num_vec=0. Expect IDLE→DRAIN, NUM_PE bubbles, job_done, and in_ready never high.
- cfg_num_w=100 with NUM_PE=8. Expect exactly 8 weights accepted (tags 0x80..0x87), then STREAM.
- cfg_start pulsed again mid-STREAM with different cfg_simd. Expect it ignored, and pe_simd_mode constant for the whole job.
- Assert rst_n low mid-STREAM. Expect all outputs 0 asynchronously and state IDLE. A following new job runs normally.
